rf_shift_host: RTL and testbench
================================

// Module: rf_shift_host
// PURPOSE
//  Host-side initiator for the byte-serial 32x64 register-file tile.
//  - Converts parallel valid/ready read/write requests into the tile's byte shift stream plus read/write command strobes.
//  - Reassembles 64-bit read data from the tile's 8-bit output.
//  - Sits on the harness/FPGA side, same clock domain as the tile.
// PARAMETERS
//  ADDR_W      5      register address width; fixed by the tile protocol
//  DATA_W      64     register data width; fixed by the tile protocol
//  RD_BIT      1      dev_cmd bit index that strobes a tile read
//  WR_BIT      2      dev_cmd bit index that strobes a tile write
// PORTS
//  clk         in   1       clock; everything is sampled on posedge
//  rst_n       in   1       synchronous active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       bridge idle, can accept a request
//  req_write   in   1       1 = write, 0 = read
//  req_addr    in   ADDR_W  register index
//  req_wdata   in   DATA_W  write data
//  rsp_valid   out  1       one-cycle completion pulse
//  rsp_rdata   out  DATA_W  read data; held until the next read completes
//  dev_cmd     out  8       drives tile ui_in; only RD_BIT/WR_BIT are ever set
//  dev_data    out  8       drives tile uio_in (shift byte)
//  dev_q       in   8       tile uo_out = top byte of the tile's shift register
// BEHAVIOUR
//  Tile contract, per edge:
//  - RD set: tile loads data <- rf[addr].
//  - else WR set: tile does rf[addr] <- data.
//  - else: tile shifts {data,addr} left by 8 and takes dev_data into the low byte.
//  - addr = low 5 bits; dev_q = data[63:56].
//  Drive rules:
//  - All dev_* outputs are registered.
//  - dev_cmd never has RD and WR set together.
//  - Every non-command cycle shifts the tile, so dev_data must always be defined; 8'h00 when unused.
//  Reset (rst_n=0 at an edge), all state and outputs:
//  - state=IDLE, dev_cmd=0, dev_data=0, rsp_valid=0, rsp_rdata=0
//  - req_ready=0 while rst_n=0; req_ready=1 from the first cycle after release.
//  - Reset mid-transaction aborts it: no rsp_valid, partial data discarded.
//  - The tile's own reset (same rst_n) clears its shift register.
//  Handshake:
//  - Request accepted on an edge with req_valid & req_ready.
//  - req_ready=1 only in IDLE.
//  - Request fields are captured at accept; the requester may change them afterwards.
//  States: IDLE -> SHIFT -> CMD -> [CAPT] -> RESP -> IDLE. Cycles below are numbered from c0, the first cycle after accept.
//  WRITE:
//  - Frame C = {3'b000, wdata, addr}, 72 bits.
//  - SHIFT c0..c8: dev_data = C[71-8i -: 8]; the MSB byte goes first.
//  - CMD c9: dev_cmd[WR_BIT]=1.
//  - RESP c10: rsp_valid=1, rsp_rdata unchanged.
//  - Latency accept->rsp = 11 cycles.
//  READ:
//  - SHIFT c0: one byte, dev_data = {3'b000, addr}.
//  - CMD c1: dev_cmd[RD_BIT]=1.
//  - CAPT c2..c9: sample dev_q at the end of each cycle into byte 7-(i-2).
//    - c2 gets data[63:56]; c9 gets data[7:0].
//    - dev_data=8'h00 throughout CAPT.
//  - RESP c10: rsp_valid=1 with the full rdata.
//  - Latency accept->rsp = 11 cycles.
//  Other rules:
//  - rsp_valid is high exactly 1 cycle per request; req_ready stays 0 during RESP.
//  - A new request can be accepted the cycle after RESP, giving back-to-back throughput of one request per 12 cycles.
//  - Address is truncated to ADDR_W. No wrap or overflow cases exist; counters are 4-bit byte indices that saturate at their terminal values.
//  - req_valid while busy: ignored, not queued.
// CONFIGURATION
//  RF_SHIFT_HOST_VERIFY_EN defined:
//  - Every write is followed by a read-back.
//  - CMD(WR) c9 -> CMD(RD) c10; no re-shift, because the tile address is still loaded.
//  - CAPT c11..c18; RESP c19; latency 20 cycles.
//  - If the captured data != wdata, the sticky output verify_err (1 bit, added port) sets on the RESP cycle.
//  - verify_err clears only on reset.
//  - rsp_rdata is updated with the read-back value.
//  Undefined:
//  - No read-back; no verify_err port.
//  - Write timing as above.
// TESTING
//  1. Release reset, then write addr=3, wdata=64'h0123_4567_89AB_CDEF -> dev_data sequence 00,24,68,AC,F1,35,79,BD,E3; WR strobe on c9; rsp_valid on c10.
//  2. Read addr=3 after test 1 -> RD strobe on c1; rsp_rdata=64'h0123_4567_89AB_CDEF on c10.
//  3. Write addr=0 then addr=31 with distinct data, read both back -> no aliasing; addr bits above 4 ignored (req_addr=5'h1F -> rf[31]).
//  4. req_valid held high for 3 back-to-back reads -> accepts 12 cycles apart; exactly 3 rsp_valid pulses; never RD and WR together.
//  5. Assert rst_n=0 at read c5 -> no rsp_valid; dev_cmd=0; req_ready=1 one cycle after release; the next read returns 0 (tile cleared).
//  6. VERIFY_EN: write with a tile model that corrupts bit 0 -> verify_err=1 at c19 and remains high; clean write -> verify_err stays 0.

Source files
------------

// File: rtl/rf_shift_host_if.sv
// Request/response bundle between a requester and rf_shift_host.
// master = requester side, slave = bridge side.
interface rf_shift_host_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/rf_shift_host.sv
// Host-side byte-serial initiator for the 32x64 register-file tile.
// Define RF_SHIFT_HOST_VERIFY_EN for write read-back and verify_err.
module rf_shift_host #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int RD_BIT = 1,
  parameter int WR_BIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  rf_shift_host_if.slave bus,
  output logic [7:0] dev_cmd,
  output logic [7:0] dev_data,
  input  logic [7:0] dev_q
`ifdef RF_SHIFT_HOST_VERIFY_EN
  ,
  output logic       verify_err
`endif
);

`ifdef RF_SHIFT_HOST_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam logic [7:0] RD_CMD = 8'b1 << RD_BIT;
  localparam logic [7:0] WR_CMD = 8'b1 << WR_BIT;
  localparam int FW = DATA_W + ADDR_W + 3;

  typedef enum logic [2:0] {
    IDLE, SHIFT, CMD, CAPT, RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              wr;
  logic              rdy;
  logic              rsp_v;
  logic [DATA_W-1:0] frm;
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] cap_nx;
  logic [FW-1:0]     c_frm;
`ifdef RF_SHIFT_HOST_VERIFY_EN
  logic [DATA_W-1:0] wd;
`endif

  assign bus.req_ready = rdy;
  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_rdata = rdata;

  assign c_frm  = {3'b000, bus.req_wdata, bus.req_addr};
  assign cap_nx = {cap[DATA_W-9:0], dev_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wr       <= 1'b0;
      rdy      <= 1'b0;
      rsp_v    <= 1'b0;
      frm      <= '0;
      cap      <= '0;
      rdata    <= '0;
      dev_cmd  <= 8'h00;
      dev_data <= 8'h00;
`ifdef RF_SHIFT_HOST_VERIFY_EN
      wd         <= '0;
      verify_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          rsp_v   <= 1'b0;
          dev_cmd <= 8'h00;
          if (rdy && bus.req_valid) begin
            rdy   <= 1'b0;
            wr    <= bus.req_write;
            cnt   <= 4'd0;
            frm   <= c_frm[DATA_W-1:0];
            state <= SHIFT;
`ifdef RF_SHIFT_HOST_VERIFY_EN
            wd    <= bus.req_wdata;
`endif
            if (bus.req_write)
              dev_data <= c_frm[FW-1 -: 8];
            else
              dev_data <= 8'(bus.req_addr);
          end else begin
            rdy      <= 1'b1;
            dev_data <= 8'h00;
          end
        end
        SHIFT: begin
          if (wr && cnt != 4'd8) begin
            dev_data <= frm[DATA_W-1 -: 8];
            frm      <= {frm[DATA_W-9:0], 8'h00};
            cnt      <= cnt + 4'd1;
          end else begin
            dev_data <= 8'h00;
            dev_cmd  <= wr ? WR_CMD : RD_CMD;
            state    <= CMD;
          end
        end
        CMD: begin
          cnt <= 4'd0;
          // tile address is still loaded after WR, so read back directly
          if (VERIFY && dev_cmd[WR_BIT]) begin
            dev_cmd <= RD_CMD;
          end else if (dev_cmd[RD_BIT]) begin
            dev_cmd <= 8'h00;
            state   <= CAPT;
          end else begin
            dev_cmd <= 8'h00;
            rsp_v   <= 1'b1;
            state   <= RESP;
          end
        end
        CAPT: begin
          cap <= cap_nx;
          if (cnt == 4'd7) begin
            rdata <= cap_nx;
            rsp_v <= 1'b1;
            state <= RESP;
`ifdef RF_SHIFT_HOST_VERIFY_EN
            if (wr && cap_nx != wd)
              verify_err <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          rsp_v <= 1'b0;
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_shift_host.sv
// Directed bench for rf_shift_host with a behavioural tile model.
// Builds with or without RF_SHIFT_HOST_VERIFY_EN.
module tb_rf_shift_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dev_cmd;
  logic [7:0] dev_data;
  logic [7:0] dev_q;
`ifdef RF_SHIFT_HOST_VERIFY_EN
  logic       verify_err;
  logic       exp_ve = 1'b0;
`endif

  rf_shift_host_if bus ();

  rf_shift_host dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dev_cmd  (dev_cmd),
    .dev_data (dev_data),
    .dev_q    (dev_q)
`ifdef RF_SHIFT_HOST_VERIFY_EN
    ,
    .verify_err (verify_err)
`endif
  );

  always #5 clk = ~clk;

  // tile model: RD loads, WR stores, otherwise shift {data,addr}
  logic [68:0] sh;
  logic [63:0] rf [32];
  logic        corrupt = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      sh <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (dev_cmd[1]) begin
      sh[68:5] <= rf[sh[4:0]];
    end else if (dev_cmd[2]) begin
      rf[sh[4:0]] <= sh[68:5] ^ {63'd0, corrupt};
    end else begin
      sh <= {sh[60:0], dev_data};
    end
  end

  assign dev_q = sh[68:61];

  int cyc = 0;
  int rsp_cnt = 0;
  int acc_t[$];
  bit both = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready) acc_t.push_back(cyc);
      if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (dev_cmd[1] && dev_cmd[2]) both <= 1'b1;
    end
  end

  int checks = 0;
  int passes = 0;
  logic [63:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic accept(input logic w, input logic [4:0] a,
                        input logic [63:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 30 && !bus.req_ready; i++) @(negedge clk);
    chk("req_ready_at_accept", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_addr  = ~a;
    bus.req_wdata = ~d;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d,
                          input logic [63:0] rb);
    logic [71:0] f;
    f = {3'b000, d, a};
    accept(1'b1, a, d);
    for (int i = 0; i < 9; i++) begin
      chk("wr_shift_byte", dev_data, f[71-8*i -: 8]);
      chk("wr_shift_idle", {bus.rsp_valid, dev_cmd}, 0);
      @(negedge clk);
    end
    chk("wr_cmd", dev_cmd, 8'h04);
    @(negedge clk);
`ifdef RF_SHIFT_HOST_VERIFY_EN
    chk("wr_rb_cmd", dev_cmd, 8'h02);
    repeat (8) @(negedge clk);
    chk("wr_rb_c18_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    exp_rdata = rb;
    chk("wr_verify_err", verify_err, exp_ve);
`else
    if (rb !== d) chk("wr_rb_arg", rb, d);
`endif
    chk("wr_rsp_valid", bus.rsp_valid, 1);
    chk("wr_rsp_rdata", bus.rsp_rdata, exp_rdata);
    chk("wr_resp_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("wr_rsp_drop", bus.rsp_valid, 0);
    chk("wr_ready_back", bus.req_ready, 1);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [63:0] exp);
    accept(1'b0, a, 64'h5555_5555_5555_5555);
    chk("rd_addr_byte", dev_data, {3'b000, a});
    chk("rd_c0_cmd", dev_cmd, 0);
    @(negedge clk);
    chk("rd_cmd", dev_cmd, 8'h02);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("rd_capt_idle", {bus.rsp_valid, dev_cmd, dev_data}, 0);
      @(negedge clk);
    end
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, exp);
    chk("rd_resp_ready", bus.req_ready, 0);
    exp_rdata = exp;
    @(negedge clk);
    chk("rd_rsp_drop", bus.rsp_valid, 0);
    chk("rd_ready_back", bus.req_ready, 1);
  endtask

  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DA = 64'hA5A5_0000_FFFF_1234;
  localparam logic [63:0] DB = 64'h5A5A_8000_0001_9876;

  initial begin
    int n0;
    int r0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", dev_cmd, 0);
    chk("rst_data", dev_data, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", bus.req_ready, 1);

    do_write(5'd3, D1, D1);
    do_read(5'd3, D1);

    do_write(5'd0, DA, DA);
    do_write(5'h1F, DB, DB);
    do_read(5'd0, DA);
    do_read(5'h1F, DB);
    do_read(5'd3, D1);

    n0 = acc_t.size();
    r0 = rsp_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 5'h1F;
    for (int i = 0; i < 60 && acc_t.size() < n0 + 3; i++)
      @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("b2b_accepts", acc_t.size() - n0, 3);
    chk("b2b_gap1", acc_t[n0+1] - acc_t[n0], 12);
    chk("b2b_gap2", acc_t[n0+2] - acc_t[n0+1], 12);
    chk("b2b_rsp_cnt", rsp_cnt - r0, 3);
    chk("b2b_rdata", bus.rsp_rdata, DB);
    chk("no_rd_wr_both", both, 0);

    accept(1'b0, 5'h1F, 64'd0);
    repeat (5) @(negedge clk);
    r0 = rsp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_cmd", dev_cmd, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_ready", bus.req_ready, 0);
    chk("abort_rdata", bus.rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", bus.req_ready, 1);
    repeat (12) @(negedge clk);
    chk("abort_no_rsp", rsp_cnt - r0, 0);
    exp_rdata = '0;
    do_read(5'h1F, 64'd0);
    do_read(5'd3, 64'd0);

`ifdef RF_SHIFT_HOST_VERIFY_EN
    corrupt = 1'b1;
    exp_ve  = 1'b1;
    do_write(5'd7, D1, D1 ^ 64'd1);
    corrupt = 1'b0;
    do_write(5'd8, DA, DA);
    chk("verify_sticky", verify_err, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("verify_rst", verify_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_ve    = 1'b0;
    exp_rdata = '0;
    do_write(5'd9, DB, DB);
    chk("verify_clean", verify_err, 0);
`endif

    chk("final_no_rd_wr_both", both, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
